// File: rtl/square_overlay_ctrl.sv
// Chess-board square overlay: hover/selected outlines on a 2-cycle VGA pipeline,
// plus the pick/place move-request handshake toward the board logic.
module square_overlay_ctrl #(
    parameter int          BOARD_X   = 256,
    parameter int          BOARD_Y   = 128,
    parameter int          SQ_SIZE   = 64,
    parameter int          BORDER    = 2,
    parameter logic [11:0] HOVER_RGB = 12'h0F0,
    parameter logic [11:0] SEL_RGB   = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  square,
    input  logic        pick_piece,
    input  logic        place_piece,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        move_valid,
    output logic [5:0]  move_src,
    output logic [5:0]  move_dst,
    input  logic        move_ready
);

    typedef enum logic [1:0] {IDLE, SELECTED, MOVE_REQ} state_t;

    state_t      state_q, state_d;
    logic [5:0]  src_q, src_d, dst_q, dst_d, hover_q, hover_d;
    logic        mv_valid_q, mv_valid_d;
    logic        pick_prev_q, place_prev_q;
    logic        pick_rise, place_rise;

    logic [10:0] hcount_p1_q, hcount_p1_d, vcount_p1_q, vcount_p1_d;
    logic        hsync_p1_q, hsync_p1_d, vsync_p1_q, vsync_p1_d;
    logic        hblnk_p1_q, hblnk_p1_d, vblnk_p1_q, vblnk_p1_d;
    logic [11:0] rgb_p1_q, rgb_p1_d;
    logic        hov_hit_p1_q, hov_hit_p1_d, sel_hit_p1_q, sel_hit_p1_d;

    logic [10:0] hcount_p2_q, vcount_p2_q;
    logic        hsync_p2_q, vsync_p2_q, hblnk_p2_q, vblnk_p2_q;
    logic [11:0] rgb_p2_q, rgb_p2_d;

    // Offsets are taken after the x0/y0 lower bound holds, so x0+SQ_SIZE never has to be formed.
    function automatic logic in_outline(input logic [10:0] h, input logic [10:0] v,
                                        input logic [5:0] sq);
        logic [10:0] x0, y0, dx, dy;
        logic        in_x, in_y, edge_x, edge_y;
        x0     = 11'(BOARD_X) + 11'(sq[5:3]) * 11'(SQ_SIZE);
        y0     = 11'(BOARD_Y) + 11'(sq[2:0]) * 11'(SQ_SIZE);
        dx     = h - x0;
        dy     = v - y0;
        in_x   = (h >= x0) && (dx < 11'(SQ_SIZE));
        in_y   = (v >= y0) && (dy < 11'(SQ_SIZE));
        edge_x = (dx < 11'(BORDER)) || (dx >= 11'(SQ_SIZE - BORDER));
        edge_y = (dy < 11'(BORDER)) || (dy >= 11'(SQ_SIZE - BORDER));
        return in_x && in_y && (edge_x || edge_y);
    endfunction

    assign pick_rise  = pick_piece  && !pick_prev_q;
    assign place_rise = place_piece && !place_prev_q;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        mv_valid_d = mv_valid_q;
        hover_d    = vblnk_in ? square : hover_q;
        case (state_q)
            IDLE: begin
                if (pick_rise) begin
                    src_d   = square;
                    state_d = SELECTED;
                end
            end
            SELECTED: begin
                if (place_rise) begin
                    if (square != src_q) begin
                        dst_d      = square;
                        mv_valid_d = 1'b1;
                        state_d    = MOVE_REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_REQ: begin
                if (mv_valid_q && move_ready) begin
                    mv_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            hover_q      <= '0;
            mv_valid_q   <= 1'b0;
            pick_prev_q  <= 1'b0;
            place_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            hover_q      <= hover_d;
            mv_valid_q   <= mv_valid_d;
            pick_prev_q  <= pick_piece;
            place_prev_q <= place_piece;
        end
    end

    // Stage p1: register timing, resolve which outlines the pixel falls on.
    always_comb begin
        hcount_p1_d  = hcount_in;
        vcount_p1_d  = vcount_in;
        hsync_p1_d   = hsync_in;
        vsync_p1_d   = vsync_in;
        hblnk_p1_d   = hblnk_in;
        vblnk_p1_d   = vblnk_in;
        rgb_p1_d     = rgb_in;
        hov_hit_p1_d = in_outline(hcount_in, vcount_in, hover_q);
        sel_hit_p1_d = (state_q != IDLE) && in_outline(hcount_in, vcount_in, src_q);
    end

    // Stage p2: colour select; blanking always passes the upstream colour.
    always_comb begin
        rgb_p2_d = rgb_p1_q;
        if (!hblnk_p1_q && !vblnk_p1_q) begin
            if (sel_hit_p1_q)      rgb_p2_d = SEL_RGB;
            else if (hov_hit_p1_q) rgb_p2_d = HOVER_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_p1_q  <= '0;
            vcount_p1_q  <= '0;
            hsync_p1_q   <= 1'b0;
            vsync_p1_q   <= 1'b0;
            hblnk_p1_q   <= 1'b0;
            vblnk_p1_q   <= 1'b0;
            rgb_p1_q     <= '0;
            hov_hit_p1_q <= 1'b0;
            sel_hit_p1_q <= 1'b0;
            hcount_p2_q  <= '0;
            vcount_p2_q  <= '0;
            hsync_p2_q   <= 1'b0;
            vsync_p2_q   <= 1'b0;
            hblnk_p2_q   <= 1'b0;
            vblnk_p2_q   <= 1'b0;
            rgb_p2_q     <= '0;
        end else begin
            hcount_p1_q  <= hcount_p1_d;
            vcount_p1_q  <= vcount_p1_d;
            hsync_p1_q   <= hsync_p1_d;
            vsync_p1_q   <= vsync_p1_d;
            hblnk_p1_q   <= hblnk_p1_d;
            vblnk_p1_q   <= vblnk_p1_d;
            rgb_p1_q     <= rgb_p1_d;
            hov_hit_p1_q <= hov_hit_p1_d;
            sel_hit_p1_q <= sel_hit_p1_d;
            hcount_p2_q  <= hcount_p1_q;
            vcount_p2_q  <= vcount_p1_q;
            hsync_p2_q   <= hsync_p1_q;
            vsync_p2_q   <= vsync_p1_q;
            hblnk_p2_q   <= hblnk_p1_q;
            vblnk_p2_q   <= vblnk_p1_q;
            rgb_p2_q     <= rgb_p2_d;
        end
    end

    assign hcount_out = hcount_p2_q;
    assign vcount_out = vcount_p2_q;
    assign hsync_out  = hsync_p2_q;
    assign vsync_out  = vsync_p2_q;
    assign hblnk_out  = hblnk_p2_q;
    assign vblnk_out  = vblnk_p2_q;
    assign rgb_out    = rgb_p2_q;
    assign move_valid = mv_valid_q;
    assign move_src   = src_q;
    assign move_dst   = dst_q;

endmodule

// File: tb/tb_square_overlay_ctrl.sv
// Scoreboard bench for square_overlay_ctrl: VGA stream expectations are queued
// per driven pixel and compared two cycles later; move handshake checked inline.
module tb_square_overlay_ctrl;
    localparam logic [11:0] HOV = 12'h0F0;
    localparam logic [11:0] SEL = 12'hFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  square;
    logic        pick_piece, place_piece, move_ready;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        move_valid;
    logic [5:0]  move_src, move_dst;

    always #5 clk = ~clk;

    square_overlay_ctrl dut (
        .clk(clk), .rst(rst), .square(square),
        .pick_piece(pick_piece), .place_piece(place_piece),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
        .move_valid(move_valid), .move_src(move_src), .move_dst(move_dst),
        .move_ready(move_ready)
    );

    typedef struct {
        int          due;
        logic [37:0] val;
    } sb_t;
    sb_t sb[$];

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    bit   push_en = 1'b0;
    bit   sel_m   = 1'b0;
    logic [5:0] hover_m = '0;
    logic [5:0] src_m   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit outl(input int h, input int v, input logic [5:0] sq);
        int x0, y0;
        x0 = 256 + 64 * int'(sq[5:3]);
        y0 = 128 + 64 * int'(sq[2:0]);
        return (h >= x0) && (h < x0 + 64) && (v >= y0) && (v < y0 + 64) &&
               ((h < x0 + 2) || (h >= x0 + 62) || (v < y0 + 2) || (v >= y0 + 62));
    endfunction

    function automatic logic [11:0] exp_rgb();
        if (hblnk_in || vblnk_in) return rgb_in;
        if (sel_m && outl(int'(hcount_in), int'(vcount_in), src_m)) return SEL;
        if (outl(int'(hcount_in), int'(vcount_in), hover_m)) return HOV;
        return rgb_in;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq("vga", {hcount_out, vcount_out, hsync_out, vsync_out,
                             hblnk_out, vblnk_out, rgb_out}, e.val);
        end
    end

    task automatic tick();
        sb_t e;
        if (push_en) begin
            e.due = cyc + 2;
            e.val = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, exp_rgb()};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (vblnk_in) hover_m = square;
    endtask

    task automatic idle_pix();
        hcount_in = 11'd3; vcount_in = 11'd7;
        hsync_in = 1'b1; vsync_in = 1'b0;
        hblnk_in = 1'b1; vblnk_in = 1'b0;
        rgb_in = 12'h5A5;
    endtask

    task automatic load_hover(input logic [5:0] sq);
        square = sq; vblnk_in = 1'b1;
        tick();
        vblnk_in = 1'b0;
    endtask

    task automatic sweep(input int xa, input int xb, input int ya, input int yb, input int hbx);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                hcount_in = 11'(x); vcount_in = 11'(y);
                hsync_in = x[0]; vsync_in = y[1];
                hblnk_in = (x >= hbx); vblnk_in = 1'b0;
                rgb_in = {x[5:0] ^ 6'h2A, y[5:0]};
                tick();
            end
        end
        idle_pix();
    endtask

    task automatic pulse_pick(input logic [5:0] sq);
        square = sq; pick_piece = 1'b1; tick();
        pick_piece = 1'b0; tick();
    endtask

    task automatic pulse_place(input logic [5:0] sq);
        square = sq; place_piece = 1'b1; tick();
        place_piece = 1'b0; tick();
    endtask

    initial begin
        int cnt;
        rst = 1'b0; square = 6'o55; pick_piece = 1'b0; place_piece = 1'b0; move_ready = 1'b1;
        hcount_in = 11'h7FF; vcount_in = 11'h3FF; hsync_in = 1'b1; vsync_in = 1'b1;
        hblnk_in = 1'b1; vblnk_in = 1'b1; rgb_in = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                               vblnk_out, rgb_out, move_valid, move_src, move_dst}, 64'd0);
        move_ready = 1'b0;
        idle_pix();
        rst = 1'b1;
        push_en = 1'b1;

        // hover outline of 6'o12, square input changed afterwards must not move it
        load_hover(6'o12);
        square = 6'o33;
        sweep(316, 387, 252, 323, 2000);

        // full move request with delayed ready
        pulse_pick(6'd0);
        check_eq("req35_idle_valid", move_valid, 0);
        square = 6'o77; place_piece = 1'b1; tick(); place_piece = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (move_valid) begin
                cnt++;
                check_eq("req35_srcdst", {move_src, move_dst}, {6'd0, 6'd63});
            end
            if (cnt == 6) move_ready = 1'b1;
            tick();
            if (!move_valid && cnt > 0) break;
        end
        check_eq("req35_valid_cycles", cnt, 6);
        move_ready = 1'b0;
        pulse_place(6'd12);
        check_eq("req35_back_idle", move_valid, 0);

        // cancel by placing on the source square
        pulse_pick(6'd5);
        check_eq("req36_src", move_src, 6'd5);
        pulse_place(6'd5);
        for (int i = 0; i < 3; i++) begin
            check_eq("req36_no_valid", move_valid, 0);
            tick();
        end
        pulse_place(6'd7);
        check_eq("req36_idle", move_valid, 0);
        load_hover(6'd5);
        sweep(252, 323, 444, 515, 2000);

        // held pick latches once; later pick in SELECTED ignored
        square = 6'd3; pick_piece = 1'b1; tick();
        square = 6'd20;
        repeat (99) tick();
        check_eq("req37_held_src", move_src, 6'd3);
        pick_piece = 1'b0; tick();
        pulse_pick(6'd40);
        check_eq("req37_second_pick", move_src, 6'd3);
        pulse_place(6'd3);
        check_eq("req37_cancel", move_valid, 0);

        // selected outline wins over hover; blanked pixels pass through
        load_hover(6'd9);
        pulse_pick(6'd9);
        check_eq("req38_src", move_src, 6'd9);
        sel_m = 1'b1; src_m = 6'd9;
        sweep(316, 387, 188, 259, 380);

        // asynchronous reset in the middle of a pending request
        square = 6'd10; place_piece = 1'b1; tick(); place_piece = 1'b0; tick();
        check_eq("req39_pending", {move_valid, move_dst}, {1'b1, 6'd10});
        push_en = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        check_eq("req39_async", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                                 vblnk_out, rgb_out, move_valid, move_src, move_dst}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        hover_m = '0; src_m = '0; sel_m = 1'b0;
        push_en = 1'b1;
        tick();
        check_eq("req39_after_rel", move_valid, 0);
        pulse_place(6'd11);
        check_eq("req39_idle", move_valid, 0);
        sweep(254, 261, 126, 133, 2000);
        pulse_pick(6'd2);
        check_eq("req39_pick", move_src, 6'd2);
        pulse_place(6'd2);

        push_en = 1'b0;
        repeat (4) tick();
        check_eq("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/square_overlay_ctrl.md
SQUARE_OVERLAY_CTRL -- requirements
Module: square_overlay_ctrl

Interface
REQ-001 Parameter BOARD_X, default 256, pixel x of board column 0 left edge.
REQ-002 Parameter BOARD_Y, default 128, pixel y of board row 0 top edge.
REQ-003 Parameter SQ_SIZE, default 64, square edge length in pixels (power of two).
REQ-004 Parameter BORDER, default 2, outline thickness in pixels.
REQ-005 Parameter HOVER_RGB, default 12'h0F0, hover outline colour.
REQ-006 Parameter SEL_RGB, default 12'hFF0, selected-square outline colour.
REQ-007 Port clk  input  1  single clock, all state on rising edge.
REQ-008 Port rst  input  1  reset, asynchronous, active-low.
REQ-009 Port square  input  6  board square under cursor; [5:3] column, [2:0] row.
REQ-010 Port pick_piece / place_piece  input  1 each  level flags from click decoder; rising edge is the event.
REQ-011 Port hcount_in / vcount_in  input  11 each  VGA pixel counters.
REQ-012 Port hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  VGA timing.
REQ-013 Port rgb_in  input  12  upstream pixel colour.
REQ-014 Ports hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  output  widths as inputs  overlaid VGA stream.
REQ-015 Port move_valid  output  1  move request pending.
REQ-016 Port move_src / move_dst  output  6 each  source / destination squares of request.
REQ-017 Port move_ready  input  1  board logic accepts request.

Function
REQ-018 Square-to-pixel mapping: x0 = BOARD_X + col*SQ_SIZE, y0 = BOARD_Y + row*SQ_SIZE, computed at 11-bit width, no truncation for defaults (max x0+63 = 767).
REQ-019 Pixel in outline of square S when x0<=hcount<x0+SQ_SIZE, y0<=vcount<y0+SQ_SIZE, and (hcount-x0<BORDER or hcount-x0>=SQ_SIZE-BORDER or same for vcount).
REQ-020 Hover square register loaded from square only on cycles with vblnk_in=1; constant across active video.
REQ-021 FSM states IDLE, SELECTED, MOVE_REQ; reset state IDLE.
REQ-022 IDLE: rising pick_piece -> src register <= square, go SELECTED.
REQ-023 SELECTED: rising place_piece with square != src -> dst <= square, move_valid <= 1, go MOVE_REQ.
REQ-024 SELECTED: rising place_piece with square == src -> cancel, go IDLE, no request.
REQ-025 MOVE_REQ: move_src/move_dst/move_valid held stable until move_valid&&move_ready sampled high; that cycle -> move_valid <= 0 next edge, go IDLE.
REQ-026 Rising pick_piece ignored outside IDLE; rising place_piece ignored outside SELECTED; same-cycle rising of both handled per current state only.
REQ-027 Edge detectors use registered previous values of pick_piece/place_piece; held levels produce one event only.
REQ-028 VGA path latency exactly 2 clk cycles for all timing and count signals; rgb_out aligned with them.
REQ-029 rgb_out priority: SEL_RGB if pixel in src outline and state in {SELECTED, MOVE_REQ}; else HOVER_RGB if in hover outline; else rgb_in (delayed).
REQ-030 During hblnk or vblnk (delayed) rgb_out = delayed rgb_in, no overlay.
REQ-031 move_src/move_dst reflect src/dst registers at all times; valid only when move_valid=1.

Reset
REQ-032 rst low asynchronously forces: state IDLE, move_valid 0, move_src/move_dst/hover/src/dst 0, edge-detect regs 0, all VGA outputs 0, rgb_out 0.
REQ-033 Reset mid-request drops move_valid immediately without waiting for move_ready; first edge after release resumes normal sampling.

Verification
REQ-034 square=6'o12 loaded in vblank, sweep frame -> HOVER_RGB exactly on pixels x 320..383, y 256..319 border 2 px; interior = rgb_in; 2-cycle latency checked.
REQ-035 pick at square 0, place at square 6'o77, move_ready=0 for 5 cycles then 1 -> move_valid high 6 cycles, src=0, dst=63 stable, then IDLE.
REQ-036 pick at square 5, place at square 5 -> no move_valid, state IDLE, SEL outline disappears.
REQ-037 pick held high 100 cycles, second pick pulse in SELECTED -> single src latch, second pulse ignored.
REQ-038 src=hover=square 9 -> outline pixels show SEL_RGB, not HOVER_RGB; blanking pixels show rgb_in.
REQ-039 rst low during MOVE_REQ -> move_valid 0 same cycle (asynchronous), all outputs 0, IDLE after release.
